// File: rtl/rs232_pkg.sv
// Shared constants, state enums and the status-word helper for the RS232 Avalon-MM slave.
package rs232_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] RX_BASE     = 5'd0;
    localparam logic [ADDR_W-1:0] TX_BASE     = 5'd4;
    localparam logic [ADDR_W-1:0] STATUS_BASE = 5'd8;

    localparam int unsigned RX_OK_BIT = 7;
    localparam int unsigned TX_OK_BIT = 6;
    localparam int unsigned ROE_BIT   = 3;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } bus_state_e;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ser_state_e;

    // What the access captured in S_IDLE must do when it completes in S_ACK.
    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_RX_READ,
        ACC_TX_WRITE
    } acc_kind_e;

    function automatic logic [DATA_W-1:0] status_word(input logic rrdy,
                                                      input logic trdy,
                                                      input logic roe);
        logic [DATA_W-1:0] w;
        w            = '0;
        w[RX_OK_BIT] = rrdy;
        w[TX_OK_BIT] = trdy;
        w[ROE_BIT]   = roe;
        return w;
    endfunction

endpackage

// File: rtl/rs232_avm_slave_if.sv
// Avalon-MM bus bundle between the polling master and the RS232 register slave.
interface rs232_avm_slave_if import rs232_pkg::*; ();

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid on a good stop bit.
module uart_rx_deserializer import rs232_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd_i,
    output logic              byte_valid_o,
    output logic [BYTE_W-1:0] byte_o
);

    localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic              sync1_q, sync2_q, prev_q;
    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;

    // Synchronize the asynchronous line and keep last cycle's value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    // Frame sequencing: half-bit start re-check, then full-bit steps sampling LSB first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[BYTE_W-1:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    valid_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;

endmodule

// File: rtl/rs232_avm_slave.sv
// RS232 register-map emulator (RX@0, TX@4, STATUS@8) bridged to an 8N1 serial line.
// Build option: RS232_LOOPBACK_EN feeds the receiver from the internal uart_txd.
module rs232_avm_slave import rs232_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic               avm_clk,
    input  logic               avm_rst,
    rs232_avm_slave_if.slave   avm,
    input  logic               uart_rxd,
    output logic               uart_txd
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bus_state_e        bus_state_q, bus_state_d;
    acc_kind_e         acc_q, acc_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              waitrequest_q, waitrequest_d;
    logic [BYTE_W-1:0] tx_hold_q, tx_hold_d;

    logic              rrdy_q, roe_q;
    logic [BYTE_W-1:0] rx_byte_q;

    ser_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;

    logic              rx_src;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              tx_idle;
    logic              rx_clear;
    logic              tx_load;
    logic              unused_wdata;

`ifdef RS232_LOOPBACK_EN
    logic unused_rxd;
    assign rx_src     = txd_q;
    assign unused_rxd = uart_rxd;
`else
    assign rx_src = uart_rxd;
`endif

    assign unused_wdata = ^avm.avm_writedata[DATA_W-1:BYTE_W];
    assign tx_idle      = (tx_state_q == IDLE);
    assign rx_clear     = (bus_state_q == S_ACK) && (acc_q == ACC_RX_READ);
    assign tx_load      = (bus_state_q == S_ACK) && (acc_q == ACC_TX_WRITE) && tx_idle;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk          (avm_clk),
        .rst          (avm_rst),
        .rxd_i        (rx_src),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_data)
    );

    // Bus FSM state and registered response.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            bus_state_q   <= S_IDLE;
            acc_q         <= ACC_NONE;
            readdata_q    <= '0;
            waitrequest_q <= 1'b1;
            tx_hold_q     <= '0;
        end else begin
            bus_state_q   <= bus_state_d;
            acc_q         <= acc_d;
            readdata_q    <= readdata_d;
            waitrequest_q <= waitrequest_d;
            tx_hold_q     <= tx_hold_d;
        end
    end

    // Decode an access in S_IDLE, complete it in S_ACK; a read wins over a simultaneous write.
    always_comb begin
        bus_state_d = bus_state_q;
        acc_d       = acc_q;
        readdata_d  = readdata_q;
        tx_hold_d   = tx_hold_q;
        case (bus_state_q)
            S_IDLE: begin
                if (avm.avm_read || avm.avm_write) begin
                    bus_state_d = S_ACK;
                    acc_d       = ACC_NONE;
                    readdata_d  = '0;
                    if (avm.avm_read) begin
                        if (avm.avm_address == RX_BASE) begin
                            acc_d      = ACC_RX_READ;
                            readdata_d = DATA_W'(rx_byte_q);
                        end else if (avm.avm_address == STATUS_BASE) begin
                            readdata_d = status_word(rrdy_q, tx_idle, roe_q);
                        end
                    end else if (avm.avm_address == TX_BASE) begin
                        acc_d     = ACC_TX_WRITE;
                        tx_hold_d = avm.avm_writedata[BYTE_W-1:0];
                    end
                end
            end
            S_ACK: begin
                bus_state_d = S_IDLE;
                acc_d       = ACC_NONE;
            end
            default: bus_state_d = S_IDLE;
        endcase
        waitrequest_d = (bus_state_d != S_ACK);
    end

    // RX holding register; a byte landing on an RX-read ack replaces the read one without overrun.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            rrdy_q    <= 1'b0;
            roe_q     <= 1'b0;
            rx_byte_q <= '0;
        end else if (rx_valid) begin
            rx_byte_q <= rx_data;
            rrdy_q    <= 1'b1;
            roe_q     <= rx_clear ? 1'b0 : (roe_q | rrdy_q);
        end else if (rx_clear) begin
            rrdy_q <= 1'b0;
            roe_q  <= 1'b0;
        end
    end

    // Transmitter state register.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // Transmit sequencing: start bit, eight data bits LSB first, stop bit, CLKS_PER_BIT each.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (tx_load) begin
                    tx_state_d = START;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_hold_q;
                    txd_d      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[BYTE_W-1:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    assign avm.avm_readdata    = readdata_q;
    assign avm.avm_waitrequest = waitrequest_q;
    assign uart_txd            = txd_q;

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Self-checking bench for rs232_avm_slave at CLKS_PER_BIT=4 with a register-map reference model.
module tb_rs232_avm_slave;

    localparam int unsigned C = 4;

    logic clk = 1'b0;
    logic rst;
    logic uart_rxd;
    logic uart_txd;

    rs232_avm_slave_if avm_if();

    rs232_avm_slave #(.CLKS_PER_BIT(C)) dut (
        .avm_clk  (clk),
        .avm_rst  (rst),
        .avm      (avm_if),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the register map.
    bit         m_rrdy;
    bit         m_roe;
    logic [7:0] m_byte;

    // Bytes decoded from uart_txd by the serial monitor.
    logic [7:0] mon_q[$];
    int         mon_bad = 0;
    logic [7:0] mon_b;

    function automatic logic [31:0] model_status(input bit trdy);
        return {24'h0, m_rrdy, trdy, 2'b00, m_roe, 3'b000};
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (good) begin
            if (m_rrdy) m_roe = 1'b1;
            m_rrdy = 1'b1;
            m_byte = b;
        end
    endfunction

    function automatic logic [7:0] model_read_rx();
        m_rrdy = 1'b0;
        m_roe  = 1'b0;
        return m_byte;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; returns readdata on the ack cycle, the cycles to ack, then idles one cycle.
    task automatic bus(input bit rd, input bit wr, input logic [4:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata, output int lat);
        avm_if.avm_address   = addr;
        avm_if.avm_read      = rd;
        avm_if.avm_write     = wr;
        avm_if.avm_writedata = wd;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (avm_if.avm_waitrequest !== 1'b0 && lat < 8);
        rdata = avm_if.avm_readdata;
        avm_if.avm_read  = 1'b0;
        avm_if.avm_write = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
            tick(C);
        end
        uart_rxd = 1'b1;
        tick(2);
    endtask

    // Serial monitor: decode every frame on uart_txd at mid-bit.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (uart_txd === 1'b0) begin
                repeat (C / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(posedge clk);
                    #2;
                    mon_b[i] = uart_txd;
                end
                repeat (C) @(posedge clk);
                #2;
                if (uart_txd !== 1'b1) mon_bad++;
                mon_q.push_back(mon_b);
            end
        end
    end

    task automatic check_status(input string name, input bit trdy);
        logic [31:0] rd;
        int          lat;
        bus(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
        checks++;
        if (rd !== model_status(trdy) || lat != 1) begin
            errors++;
            $display("FAIL %s: status %h lat %0d, expected %h lat 1", name, rd, lat, model_status(trdy));
        end
    endtask

    task automatic check_rx_read(input string name);
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        exp = {24'h0, model_read_rx()};
        bus(1'b1, 1'b0, 5'd0, 32'h0, rd, lat);
        checks++;
        if (rd !== exp || lat != 1) begin
            errors++;
            $display("FAIL %s: rx %h lat %0d, expected %h lat 1", name, rd, lat, exp);
        end
    endtask

    task automatic check_mon(input string name, input int n, input logic [7:0] b);
        checks++;
        if (mon_q.size() != n || (n > 0 && mon_q[0] !== b)) begin
            errors++;
            $display("FAIL %s: %0d tx bytes first %h, expected %0d bytes first %h",
                     name, mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 8'h00, n, b);
        end
        mon_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (avm_if.avm_waitrequest !== 1'b1 || avm_if.avm_readdata !== 32'h0 || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL reset: wr %b rd %h txd %b, expected 1 0 1",
                     avm_if.avm_waitrequest, avm_if.avm_readdata, uart_txd);
        end
        rst = 1'b0;
        m_rrdy = 0; m_roe = 0; m_byte = 8'h00;
        tick(1);
        check_status("reset_status", 1'b1);
        checks++;
        if (avm_if.avm_waitrequest !== 1'b1 || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL post_ack: wr %b txd %b, expected 1 1", avm_if.avm_waitrequest, uart_txd);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        avm_if.avm_address = 5'd8;
        avm_if.avm_read    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (avm_if.avm_waitrequest === 1'b0) acks++;
        end
        avm_if.avm_read = 1'b0;
        tick(2);
        checks++;
        if (acks != 3) begin
            errors++;
            $display("FAIL held_read: %0d acks in 6 cycles, expected 3", acks);
        end
    endtask

    task automatic test_tx_bits(input logic [7:0] b);
        logic [31:0] rd;
        int          lat;
        int          bad = 0;
        bit          exp;
        bus(1'b0, 1'b1, 5'd4, {24'hFFFFFF, b}, rd, lat);
        for (int i = 0; i < 10 * C; i++) begin
            exp = (i / C == 0) ? 1'b0 : (i / C == 9) ? 1'b1 : b[i/C-1];
            if (uart_txd !== exp) bad++;
            tick(1);
        end
        checks++;
        if (bad != 0 || lat != 1) begin
            errors++;
            $display("FAIL tx_bits %h: %0d wrong bit cycles lat %0d, expected 0 lat 1", b, bad, lat);
        end
        check_status("tx_done_status", 1'b1);
        check_mon("tx_bits_mon", 1, b);
    endtask

    task automatic test_tx_busy();
        logic [31:0] rd;
        int          lat;
        logic [7:0]  b1, b2;
        b1 = 8'($urandom);
        b2 = ~b1;
        bus(1'b0, 1'b1, 5'd4, {24'h0, b1}, rd, lat);
        tick(4);
        check_status("tx_mid_status", 1'b0);
        bus(1'b0, 1'b1, 5'd4, {24'h0, b2}, rd, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL busy_write_ack: lat %0d, expected 1", lat);
        end
        tick(10 * C);
        check_status("tx_busy_after", 1'b1);
        check_mon("tx_busy_mon", 1, b1);
    endtask

    task automatic test_rx_basic();
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        tick(4);
        check_status("rx_status", 1'b1);
        check_rx_read("rx_read");
        check_status("rx_cleared", 1'b1);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        tick(4);
        check_status("ovr_status", 1'b1);
        check_rx_read("ovr_read");
        check_status("ovr_cleared", 1'b1);
    endtask

    task automatic test_rx_errors();
        send_frame(8'($urandom), 1'b0);
        tick(4);
        check_status("framing_err", 1'b1);
        uart_rxd = 1'b0;
        tick(1);
        uart_rxd = 1'b1;
        tick(12 * C);
        check_status("glitch", 1'b1);
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        int          lat;
        logic [4:0]  addrs[4];
        addrs = '{5'd1, 5'd12, 5'd16, 5'd31};
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 1'b0, addrs[i], 32'h0, rd, lat);
            checks++;
            if (rd !== 32'h0 || lat != 1) begin
                errors++;
                $display("FAIL unmapped_read %0d: %h lat %0d, expected 0 lat 1", addrs[i], rd, lat);
            end
        end
        bus(1'b0, 1'b1, 5'd12, 32'h5A, rd, lat);
        bus(1'b1, 1'b1, 5'd4, 32'hC3, rd, lat);
        checks++;
        if (rd !== 32'h0 || lat != 1) begin
            errors++;
            $display("FAIL rw_both: %h lat %0d, expected 0 lat 1", rd, lat);
        end
        check_status("no_tx_status", 1'b1);
        tick(11 * C);
        check_mon("no_tx_mon", 0, 8'h00);
    endtask

    task automatic test_random_rx();
        for (int it = 0; it < 6; it++) begin
            int n;
            n = int'($urandom_range(1, 2));
            for (int f = 0; f < n; f++) begin
                logic [7:0] b;
                bit         good;
                b    = 8'($urandom);
                good = ($urandom_range(0, 3) != 0);
                send_frame(b, good);
                model_frame(b, good);
            end
            tick(4);
            check_status("rand_status", 1'b1);
            if ($urandom_range(0, 1) == 1 || it == 5) check_rx_read("rand_read");
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        int          lat;
        bus(1'b0, 1'b1, 5'd4, 32'h00, rd, lat);
        tick(3 * C);
        rst = 1'b1;
        tick(1);
        checks++;
        if (uart_txd !== 1'b1 || avm_if.avm_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe: txd %b wr %b, expected 1 1", uart_txd, avm_if.avm_waitrequest);
        end
        rst = 1'b0;
        m_rrdy = 0; m_roe = 0; m_byte = 8'h00;
        tick(11 * C);
        mon_q.delete();
        mon_bad = 0;
        check_status("reset_midframe_status", 1'b1);
    endtask

`ifdef RS232_LOOPBACK_EN
    task automatic test_loopback();
        logic [31:0] rd;
        int          lat;
        bus(1'b0, 1'b1, 5'd4, 32'h5A, rd, lat);
        model_frame(8'h5A, 1'b1);
        tick(12 * C);
        check_status("loop_status", 1'b1);
        check_rx_read("loop_read");
        mon_q.delete();
    endtask
`endif

    initial begin
        uart_rxd             = 1'b1;
        rst                  = 1'b1;
        avm_if.avm_address   = '0;
        avm_if.avm_read      = 1'b0;
        avm_if.avm_write     = 1'b0;
        avm_if.avm_writedata = '0;
        test_reset();
        test_back_to_back();
`ifdef RS232_LOOPBACK_EN
        test_loopback();
`else
        test_tx_bits(8'hA5);
        test_tx_bits(8'($urandom));
        test_tx_busy();
        test_rx_basic();
        test_overrun();
        test_rx_errors();
        test_unmapped();
        test_random_rx();
        test_reset_midframe();
`endif
        checks++;
        if (mon_bad != 0) begin
            errors++;
            $display("FAIL tx_stop_bits: %0d bad stop bits, expected 0", mon_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
